// File: rtl/plab4_net_ring_endpoint_pkg.sv
// Shared helpers for the ring endpoint: network message geometry.
// Layout msb->lsb is dest[s], src[s], opaque[o], payload[p].
package plab4_net_ring_endpoint_pkg;

  function automatic int net_msg_nbits(input int p, input int o, input int s);
    return 2 * s + o + p;
  endfunction

  function automatic int net_rx_nbits(input int p, input int o, input int s);
    return s + o + p;
  endfunction

endpackage

// File: rtl/plab4_net_ring_endpoint_queue.sv
// Two-entry normal queue: enqueue-to-head latency of one cycle, no
// combinational paths from enq to deq or from deq_rdy to enq_rdy.
module plab4_net_ring_endpoint_queue #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_val,
  output logic             enq_rdy,
  input  logic [WIDTH-1:0] enq_msg,
  output logic             deq_val,
  input  logic             deq_rdy,
  output logic [WIDTH-1:0] deq_msg
);

  logic             head_q, head_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             enq_fire, deq_fire, tail;

  assign enq_rdy  = (cnt_q != 2'd2);
  assign deq_val  = (cnt_q != 2'd0);
  assign deq_msg  = mem_q[head_q];
  assign enq_fire = enq_val & enq_rdy;
  assign deq_fire = deq_val & deq_rdy;
  assign tail     = head_q ^ cnt_q[0];

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    cnt_d  = cnt_q + 2'(enq_fire) - 2'(deq_fire);
    if (enq_fire) mem_d[tail] = enq_msg;
    if (deq_fire) head_d = ~head_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/plab4_net_ring_endpoint.sv
// Ring network endpoint: packs client sends into tagged messages for the
// ring port and unpacks ejected messages addressed here for the client.
module plab4_net_ring_endpoint
  import plab4_net_ring_endpoint_pkg::*;
#(
  parameter int p_payload_nbits = 32,
  parameter int p_opaque_nbits  = 3,
  parameter int p_srcdest_nbits = 3,
  parameter int p_router_id     = 0,
  parameter int p_num_ports     = 8,
  parameter int c_net_msg_nbits = net_msg_nbits(p_payload_nbits, p_opaque_nbits, p_srcdest_nbits)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       send_val,
  output logic                       send_rdy,
  input  logic [p_srcdest_nbits-1:0] send_dest,
  input  logic [p_payload_nbits-1:0] send_payload,
  output logic                       inj_val,
  input  logic                       inj_rdy,
  output logic [c_net_msg_nbits-1:0] inj_msg,
  input  logic                       ej_val,
  output logic                       ej_rdy,
  input  logic [c_net_msg_nbits-1:0] ej_msg,
  output logic                       recv_val,
  input  logic                       recv_rdy,
  output logic [p_srcdest_nbits-1:0] recv_src,
  output logic [p_opaque_nbits-1:0]  recv_opaque,
  output logic [p_payload_nbits-1:0] recv_payload,
  output logic [15:0]                tx_count,
  output logic [15:0]                rx_count,
  output logic                       err_bad_dest,
  output logic                       err_misroute
);

  localparam int P = p_payload_nbits;
  localparam int O = p_opaque_nbits;
  localparam int S = p_srcdest_nbits;
  localparam int M = c_net_msg_nbits;
  localparam int R = net_rx_nbits(P, O, S);
  localparam logic [S-1:0] ROUTER_ID = S'(p_router_id);
  localparam logic [S:0]   NUM_PORTS = (S+1)'(p_num_ports);

  logic [O-1:0] tag_q, tag_d;
  logic [15:0]  tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic         err_bad_dest_q, err_bad_dest_d, err_misroute_q, err_misroute_d;

  logic         tx_enq_val, tx_enq_rdy, tx_deq_val, tx_deq_rdy;
  logic [M-1:0] tx_enq_msg, tx_deq_msg;
  logic         rx_enq_val, rx_enq_rdy, rx_deq_val, rx_deq_rdy;
  logic [R-1:0] rx_deq_msg;
  logic         send_fire, send_dest_ok, inj_fire, ej_fire, ej_for_us;
  logic [S-1:0] ej_dest;

  // Ready/valid outputs are held low while reset is asserted.
  assign send_rdy     = tx_enq_rdy & ~reset;
  assign send_fire    = send_val & send_rdy;
  assign send_dest_ok = ({1'b0, send_dest} < NUM_PORTS);
  assign tx_enq_val   = send_fire & send_dest_ok;
  assign tx_enq_msg   = {send_dest, ROUTER_ID, tag_q, send_payload};

  assign inj_val      = tx_deq_val & ~reset;
  assign inj_msg      = tx_deq_msg;
  assign tx_deq_rdy   = inj_rdy & ~reset;
  assign inj_fire     = inj_val & inj_rdy;

  assign ej_rdy       = rx_enq_rdy & ~reset;
  assign ej_fire      = ej_val & ej_rdy;
  assign ej_dest      = ej_msg[M-1 -: S];
  assign ej_for_us    = (ej_dest == ROUTER_ID);
  assign rx_enq_val   = ej_fire & ej_for_us;

  assign recv_val     = rx_deq_val & ~reset;
  assign rx_deq_rdy   = recv_rdy & ~reset;
  assign recv_src     = rx_deq_msg[R-1 -: S];
  assign recv_opaque  = rx_deq_msg[P+O-1 -: O];
  assign recv_payload = rx_deq_msg[P-1:0];

  assign tx_count     = tx_count_q;
  assign rx_count     = rx_count_q;
  assign err_bad_dest = err_bad_dest_q;
  assign err_misroute = err_misroute_q;

  plab4_net_ring_endpoint_queue #(.WIDTH(M)) tx_queue (
    .clk     (clk),
    .reset   (reset),
    .enq_val (tx_enq_val),
    .enq_rdy (tx_enq_rdy),
    .enq_msg (tx_enq_msg),
    .deq_val (tx_deq_val),
    .deq_rdy (tx_deq_rdy),
    .deq_msg (tx_deq_msg)
  );

  // Destination field is stripped; only src/opaque/payload are buffered.
  plab4_net_ring_endpoint_queue #(.WIDTH(R)) rx_queue (
    .clk     (clk),
    .reset   (reset),
    .enq_val (rx_enq_val),
    .enq_rdy (rx_enq_rdy),
    .enq_msg (ej_msg[R-1:0]),
    .deq_val (rx_deq_val),
    .deq_rdy (rx_deq_rdy),
    .deq_msg (rx_deq_msg)
  );

  always_comb begin
    tag_d          = tag_q;
    tx_count_d     = tx_count_q;
    rx_count_d     = rx_count_q;
    err_bad_dest_d = err_bad_dest_q;
    err_misroute_d = err_misroute_q;
    if (tx_enq_val)              tag_d          = tag_q + 1'b1;
    if (send_fire & ~send_dest_ok) err_bad_dest_d = 1'b1;
    if (inj_fire)                tx_count_d     = tx_count_q + 16'd1;
    if (rx_enq_val)              rx_count_d     = rx_count_q + 16'd1;
    if (ej_fire & ~ej_for_us)    err_misroute_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q          <= '0;
      tx_count_q     <= '0;
      rx_count_q     <= '0;
      err_bad_dest_q <= 1'b0;
      err_misroute_q <= 1'b0;
    end else begin
      tag_q          <= tag_d;
      tx_count_q     <= tx_count_d;
      rx_count_q     <= rx_count_d;
      err_bad_dest_q <= err_bad_dest_d;
      err_misroute_q <= err_misroute_d;
    end
  end

endmodule

// File: tb/tb_plab4_net_ring_endpoint.sv
// Bench for plab4_net_ring_endpoint at router id 2 with six legal ports,
// so that 3-bit destinations 6 and 7 exercise the bad-destination path.
module tb_plab4_net_ring_endpoint;

  localparam int P = 32;
  localparam int O = 3;
  localparam int S = 3;
  localparam int M = 2 * S + O + P;
  localparam int R = S + O + P;
  localparam logic [S-1:0] RID = 3'd2;

  logic         clk, reset;
  logic         send_val, send_rdy;
  logic [S-1:0] send_dest;
  logic [P-1:0] send_payload;
  logic         inj_val, inj_rdy;
  logic [M-1:0] inj_msg;
  logic         ej_val, ej_rdy;
  logic [M-1:0] ej_msg;
  logic         recv_val, recv_rdy;
  logic [S-1:0] recv_src;
  logic [O-1:0] recv_opaque;
  logic [P-1:0] recv_payload;
  logic [15:0]  tx_count, rx_count;
  logic         err_bad_dest, err_misroute;

  plab4_net_ring_endpoint #(
    .p_payload_nbits (P),
    .p_opaque_nbits  (O),
    .p_srcdest_nbits (S),
    .p_router_id     (2),
    .p_num_ports     (6)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .send_val     (send_val),
    .send_rdy     (send_rdy),
    .send_dest    (send_dest),
    .send_payload (send_payload),
    .inj_val      (inj_val),
    .inj_rdy      (inj_rdy),
    .inj_msg      (inj_msg),
    .ej_val       (ej_val),
    .ej_rdy       (ej_rdy),
    .ej_msg       (ej_msg),
    .recv_val     (recv_val),
    .recv_rdy     (recv_rdy),
    .recv_src     (recv_src),
    .recv_opaque  (recv_opaque),
    .recv_payload (recv_payload),
    .tx_count     (tx_count),
    .rx_count     (rx_count),
    .err_bad_dest (err_bad_dest),
    .err_misroute (err_misroute)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [M-1:0] exp_inj_q [$];
  logic [R-1:0] exp_rx_q  [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (inj_val && inj_rdy) begin
        if (exp_inj_q.size() == 0) chk("inj_unexpected", 64'(inj_msg), 64'(0));
        else begin
          logic [M-1:0] e;
          e = exp_inj_q.pop_front();
          chk("inj_msg", 64'(inj_msg), 64'(e));
        end
      end
      if (recv_val && recv_rdy) begin
        if (exp_rx_q.size() == 0) chk("recv_unexpected", 64'({recv_src, recv_opaque, recv_payload}), 64'(0));
        else begin
          logic [R-1:0] e;
          e = exp_rx_q.pop_front();
          chk("recv_msg", 64'({recv_src, recv_opaque, recv_payload}), 64'(e));
        end
      end
    end
  end

  // Drives one request from posedge+1; returns at posedge+1 after transfer.
  task automatic do_send(input logic [S-1:0] dest, input logic [P-1:0] pay,
                         input logic [O-1:0] opq, input bit ok);
    int n;
    send_val = 1'b1; send_dest = dest; send_payload = pay;
    n = 0;
    @(negedge clk);
    while (!send_rdy && n < 20) begin @(negedge clk); n++; end
    if (send_rdy) begin
      if (ok) exp_inj_q.push_back({dest, RID, opq, pay});
    end else chk("send_rdy_timeout", 64'(send_rdy), 64'(1));
    @(posedge clk); #1;
    send_val = 1'b0;
  endtask

  task automatic do_ej(input logic [S-1:0] dest, input logic [S-1:0] src,
                       input logic [O-1:0] opq, input logic [P-1:0] pay, input bit deliver);
    int n;
    ej_val = 1'b1; ej_msg = {dest, src, opq, pay};
    n = 0;
    @(negedge clk);
    while (!ej_rdy && n < 20) begin @(negedge clk); n++; end
    if (ej_rdy) begin
      if (deliver) exp_rx_q.push_back({src, opq, pay});
    end else chk("ej_rdy_timeout", 64'(ej_rdy), 64'(1));
    @(posedge clk); #1;
    ej_val = 1'b0;
  endtask

  typedef struct {
    logic [S-1:0] dest;
    logic [P-1:0] pay;
    logic [O-1:0] exp_opq;
    bit           exp_ok;
  } send_vec_t;

  typedef struct {
    logic [S-1:0] dest;
    logic [S-1:0] src;
    logic [O-1:0] opq;
    logic [P-1:0] pay;
    bit           deliver;
  } ej_vec_t;

  send_vec_t sv [10];
  ej_vec_t   ev [4];

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_send_rdy"}, 64'(send_rdy), 64'(0));
    chk({tag, "_ej_rdy"},   64'(ej_rdy),   64'(0));
    chk({tag, "_inj_val"},  64'(inj_val),  64'(0));
    chk({tag, "_recv_val"}, 64'(recv_val), 64'(0));
    chk({tag, "_tx_count"}, 64'(tx_count), 64'(0));
    chk({tag, "_rx_count"}, 64'(rx_count), 64'(0));
    chk({tag, "_err_bad"},  64'(err_bad_dest), 64'(0));
    chk({tag, "_err_mis"},  64'(err_misroute), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    // Nine legal sends continuing from tag 2, with one bad destination.
    sv[0] = '{3'd5, 32'h1111_0000, 3'd2, 1'b1};
    sv[1] = '{3'd2, 32'h2222_0001, 3'd3, 1'b1};
    sv[2] = '{3'd4, 32'h3333_0002, 3'd4, 1'b1};
    sv[3] = '{3'd0, 32'h4444_0003, 3'd5, 1'b1};
    sv[4] = '{3'd1, 32'h5555_0004, 3'd6, 1'b1};
    sv[5] = '{3'd3, 32'h6666_0005, 3'd7, 1'b1};
    sv[6] = '{3'd6, 32'hBAD0_0006, 3'd0, 1'b0};
    sv[7] = '{3'd5, 32'h7777_0007, 3'd0, 1'b1};
    sv[8] = '{3'd1, 32'h8888_0008, 3'd1, 1'b1};
    sv[9] = '{3'd3, 32'h9999_0009, 3'd2, 1'b1};
    ev[0] = '{3'd2, 3'd2, 3'd7, 32'hFFFF_FFFF, 1'b1};
    ev[1] = '{3'd7, 3'd3, 3'd1, 32'h0000_00AA, 1'b0};
    ev[2] = '{3'd2, 3'd0, 3'd0, 32'h0000_0000, 1'b1};
    ev[3] = '{3'd2, 3'd5, 3'd5, 32'h5555_5555, 1'b1};

    reset = 1'b1; send_val = 1'b0; send_dest = '0; send_payload = '0;
    inj_rdy = 1'b0; ej_val = 1'b0; ej_msg = '0; recv_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_send_rdy", 64'(send_rdy), 64'(1));
    chk("post_rst_ej_rdy",   64'(ej_rdy),   64'(1));
    @(posedge clk); #1;

    // First injection: one-cycle latency, tags 0 then 1.
    inj_rdy = 1'b1;
    do_send(3'd5, 32'hDEAD_BEEF, 3'd0, 1'b1);
    @(negedge clk);
    chk("first_inj_val", 64'(inj_val), 64'(1));
    chk("first_inj_msg", 64'(inj_msg), 64'({3'd5, 3'd2, 3'd0, 32'hDEAD_BEEF}));
    chk("tx_count_before", 64'(tx_count), 64'(0));
    @(posedge clk); #1;
    chk("tx_count_1", 64'(tx_count), 64'(1));
    do_send(3'd3, 32'h0BAD_F00D, 3'd1, 1'b1);

    for (int i = 0; i < 10; i++) do_send(sv[i].dest, sv[i].pay, sv[i].exp_opq, sv[i].exp_ok);
    repeat (3) @(posedge clk); #1;
    chk("tx_count_11",   64'(tx_count),     64'(11));
    chk("err_bad_dest",  64'(err_bad_dest), 64'(1));
    chk("inj_idle",      64'(inj_val),      64'(0));

    // Backpressure: two fill the buffer, third waits for a free slot.
    inj_rdy = 1'b0;
    do_send(3'd1, 32'hAAAA_0001, 3'd3, 1'b1);
    do_send(3'd4, 32'hBBBB_0002, 3'd4, 1'b1);
    send_val = 1'b1; send_dest = 3'd5; send_payload = 32'hCCCC_0003;
    @(negedge clk);
    chk("full_send_rdy", 64'(send_rdy), 64'(0));
    @(posedge clk); #1;
    inj_rdy = 1'b1;
    @(negedge clk);
    chk("full_deq_send_rdy", 64'(send_rdy), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("rdy_rises", 64'(send_rdy), 64'(1));
    if (send_rdy) exp_inj_q.push_back({3'd5, RID, 3'd5, 32'hCCCC_0003});
    @(posedge clk); #1;
    send_val = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("tx_count_14", 64'(tx_count), 64'(14));

    // Receive path.
    recv_rdy = 1'b1;
    do_ej(3'd2, 3'd6, 3'd3, 32'h0000_1234, 1'b1);
    @(negedge clk);
    chk("recv_val_1",     64'(recv_val),     64'(1));
    chk("recv_src_1",     64'(recv_src),     64'(6));
    chk("recv_opaque_1",  64'(recv_opaque),  64'(3));
    chk("recv_payload_1", 64'(recv_payload), 64'(32'h1234));
    @(posedge clk); #1;
    chk("rx_count_1", 64'(rx_count), 64'(1));
    do_ej(3'd4, 3'd1, 3'd2, 32'h0000_4444, 1'b0);
    @(negedge clk);
    chk("err_misroute", 64'(err_misroute), 64'(1));
    chk("misroute_no_recv", 64'(recv_val), 64'(0));
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) do_ej(ev[i].dest, ev[i].src, ev[i].opq, ev[i].pay, ev[i].deliver);
    repeat (3) @(posedge clk); #1;
    chk("rx_count_4", 64'(rx_count), 64'(4));

    // Both directions back up together, then reset discards everything.
    recv_rdy = 1'b0; inj_rdy = 1'b0;
    fork
      begin
        do_send(3'd0, 32'hD0D0_0000, 3'd6, 1'b1);
        do_send(3'd2, 32'hD0D0_0001, 3'd7, 1'b1);
      end
      begin
        do_ej(3'd2, 3'd1, 3'd4, 32'hE0E0_0000, 1'b1);
        do_ej(3'd2, 3'd3, 3'd6, 32'hE0E0_0001, 1'b1);
      end
    join
    ej_val = 1'b1; ej_msg = {RID, 3'd4, 3'd0, 32'hE0E0_0002};
    @(negedge clk);
    chk("rx_full_ej_rdy",   64'(ej_rdy),   64'(0));
    chk("tx_full_send_rdy", 64'(send_rdy), 64'(0));
    chk("rx_full_recv_val", 64'(recv_val), 64'(1));
    @(posedge clk); #1;
    reset = 1'b1; ej_val = 1'b0;
    exp_inj_q.delete();
    exp_rx_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    reset = 1'b0; recv_rdy = 1'b1; inj_rdy = 1'b1;
    @(negedge clk);
    chk("lost_inj_val",  64'(inj_val),  64'(0));
    chk("lost_recv_val", 64'(recv_val), 64'(0));
    @(posedge clk); #1;
    do_send(3'd5, 32'h0000_0077, 3'd0, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("tx_count_after_rst", 64'(tx_count), 64'(1));
    chk("inj_sb_empty", 64'(exp_inj_q.size()), 64'(0));
    chk("rx_sb_empty",  64'(exp_rx_q.size()),  64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
